// File: rtl/dump_datapath.sv
// Digest output stage: takes squeezed rate blocks and streams them out lane by lane
// as byte-swapped W-bit words, masking the final word and requesting extra squeezes.
module dump_datapath #(
    parameter int         W                 = 64,
    parameter int         RATE_MAX          = 1344,
    parameter logic [1:0] SHAKE128_MODE_VEC = 2'b00,
    parameter logic [1:0] SHAKE256_MODE_VEC = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [1:0]          operation_mode_i,
    input  logic [31:0]         output_size_i,
    input  logic [RATE_MAX-1:0] state_i,
    input  logic                state_valid_i,
    output logic                state_ready_o,
    output logic                squeeze_req_o,
    output logic [W-1:0]        data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic                done_o
);

    localparam int         NBYTES     = W / 8;
    localparam logic [4:0] DEPTH_S128 = 5'd21;
    localparam logic [4:0] DEPTH_S256 = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BLOCK,
        S_DUMP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [31:0]           words_left_q, words_left_d;
    logic [2:0]            tail_q, tail_d;
    logic [4:0]            lane_cnt_q, lane_cnt_d;
    logic [RATE_MAX-1:0]   buf_q, buf_d;

    logic [31:0] words_req;
    logic [2:0]  tail_req;
    logic [4:0]  depth;
    logic        dumping;
    logic        transfer;
    logic        last_word;
    logic        mask_en;
    logic [W-1:0] lane_w;
    logic        unused_size_bits;

    // Sub-byte size bits carry no meaning; the digest is always whole bytes.
    assign unused_size_bits = ^output_size_i[2:0];

    // Word count is the byte count rounded up to whole 8-byte words.
    assign tail_req  = output_size_i[5:3];
    assign words_req = {6'd0, output_size_i[31:6]} + {31'd0, |tail_req};

    assign depth = (mode_q == SHAKE256_MODE_VEC) ? DEPTH_S256 : DEPTH_S128;

    assign dumping   = (state_q == S_DUMP);
    assign transfer  = dumping && ready_i;
    assign last_word = dumping && (words_left_q == 32'd1);
    assign mask_en   = last_word && (tail_q != 3'd0);
    assign lane_w    = buf_q[W-1:0];

    assign valid_o       = dumping;
    assign last_o        = last_word;
    assign state_ready_o = (state_q == S_WAIT_BLOCK);
    assign done_o        = (state_q == S_DONE);
    assign squeeze_req_o = transfer && (lane_cnt_q == 5'd1) && (words_left_q > 32'd1);

    // Lane byte 0 lands on the most significant byte; bytes past the tail are zeroed.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            logic keep;
            assign keep = !mask_en || (3'(gi) < tail_q);
            assign data_o[W-1-8*gi -: 8] = (dumping && keep) ? lane_w[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        words_left_d = words_left_q;
        tail_d       = tail_q;
        lane_cnt_d   = lane_cnt_q;
        buf_d        = buf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d       = operation_mode_i;
                    words_left_d = words_req;
                    tail_d       = tail_req;
                    state_d      = (words_req == 32'd0) ? S_DONE : S_WAIT_BLOCK;
                end
            end
            S_WAIT_BLOCK: begin
                if (state_valid_i) begin
                    buf_d      = state_i;
                    lane_cnt_d = depth;
                    state_d    = S_DUMP;
                end
            end
            S_DUMP: begin
                if (transfer) begin
                    buf_d        = buf_q >> W;
                    lane_cnt_d   = lane_cnt_q - 5'd1;
                    words_left_d = words_left_q - 32'd1;
                    if (words_left_q == 32'd1) begin
                        state_d = S_DONE;
                    end else if (lane_cnt_q == 5'd1) begin
                        state_d = S_WAIT_BLOCK;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 2'd0;
            words_left_q <= 32'd0;
            tail_q       <= 3'd0;
            lane_cnt_q   <= 5'd0;
            buf_q        <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            words_left_q <= words_left_d;
            tail_q       <= tail_d;
            lane_cnt_q   <= lane_cnt_d;
            buf_q        <= buf_d;
        end
    end

endmodule

// File: tb/tb_dump_datapath.sv
// Scoreboard bench for dump_datapath: expected words are queued per message and
// popped on every output transfer.
module tb_dump_datapath;

    localparam int         W        = 64;
    localparam int         RATE_MAX = 1344;
    localparam logic [1:0] M128     = 2'b00;
    localparam logic [1:0] M256     = 2'b01;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start_i = 1'b0;
    logic [1:0]          operation_mode_i = 2'b00;
    logic [31:0]         output_size_i = 32'd0;
    logic [RATE_MAX-1:0] state_i = '0;
    logic                state_valid_i = 1'b0;
    logic                state_ready_o;
    logic                squeeze_req_o;
    logic [W-1:0]        data_o;
    logic                valid_o;
    logic                ready_i = 1'b0;
    logic                last_o;
    logic                done_o;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;
    logic [64:0] sb[$];

    dump_datapath #(.W(W), .RATE_MAX(RATE_MAX)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .operation_mode_i (operation_mode_i),
        .output_size_i    (output_size_i),
        .state_i          (state_i),
        .state_valid_i    (state_valid_i),
        .state_ready_o    (state_ready_o),
        .squeeze_req_o    (squeeze_req_o),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .last_o           (last_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane_val(input int pat, input int blk, input int l);
        logic [63:0] v;
        case (pat)
            1:       v = 64'hC3A5_0000_0000_0000 ^ (64'(blk) << 40) ^ (64'(l) * 64'h0001_0203_0405_0607);
            2:       v = (l == 3) ? 64'h1122_3344_5566_7788 : 64'(l);
            default: v = 64'(l);
        endcase
        return v;
    endfunction

    function automatic logic [RATE_MAX-1:0] build_block(input int pat, input int blk);
        logic [RATE_MAX-1:0] b;
        b = '0;
        for (int l = 0; l < RATE_MAX / 64; l++) b[64*l +: 64] = lane_val(pat, blk, l);
        return b;
    endfunction

    function automatic logic [63:0] swap_mask(input logic [63:0] v, input int keep);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[63-8*k -: 8] = (k < keep) ? v[8*k +: 8] : 8'h00;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(valid_o), 64'd0);
        check({tag, "_last"}, 64'(last_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_sready"}, 64'(state_ready_o), 64'd0);
        check({tag, "_squeeze"}, 64'(squeeze_req_o), 64'd0);
        check({tag, "_data"}, data_o, 64'd0);
    endtask

    // Runs one message; abort_at > 0 pulls reset after that many words.
    task automatic run_msg(input logic [1:0] mode, input int size, input int pat,
                           input bit bp, input int abort_at);
        int bytes, words, depth, tail, keep, blk, widx, last_x, squeezes, exp_sq, budget;
        bit stalled, hs, seen_rdy, seen_val, exp_sqz;
        logic [63:0] pd;
        logic pl;
        logic [64:0] e;

        bytes  = size / 8;
        words  = (bytes + 7) / 8;
        tail   = bytes % 8;
        depth  = (mode == M256) ? 17 : 21;
        exp_sq = (words > 0) ? (words - 1) / depth : 0;
        for (int i = 0; i < words; i++) begin
            keep = (i == words - 1 && tail != 0) ? tail : 8;
            e = {(i == words - 1), swap_mask(lane_val(pat, i / depth, i % depth), keep)};
            sb.push_back(e);
        end

        blk = 0;
        operation_mode_i = mode;
        output_size_i    = 32'(size) | ((pat == 1) ? 32'd5 : 32'd0);
        state_i          = build_block(pat, 0);
        state_valid_i    = 1'b1;
        ready_i          = !bp;
        start_i          = 1'b1;
        last_x           = cycle;
        @(posedge clk); #1;
        start_i = 1'b0;

        widx = 0; squeezes = 0; stalled = 0; budget = 0;
        seen_rdy = 0; seen_val = 0; pd = '0; pl = 1'b0;
        while (1) begin
            @(negedge clk);
            if (abort_at > 0 && widx == abort_at) begin
                rst = 1'b0;
                #1;
                check_all_zero("abort");
                sb.delete();
                @(posedge clk); #1;
                rst = 1'b1;
                state_valid_i = 1'b0;
                ready_i = 1'b0;
                return;
            end
            if (state_ready_o) seen_rdy = 1;
            if (valid_o) seen_val = 1;
            if (valid_o && stalled) begin
                check("hold_data", data_o, pd);
                check("hold_last", 64'(last_o), 64'(pl));
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check("extra_word", 64'(widx), 64'(words));
                end else begin
                    e = sb.pop_front();
                    check($sformatf("data_w%0d", widx), data_o, e[63:0]);
                    check($sformatf("last_w%0d", widx), 64'(last_o), 64'(e[64]));
                end
                exp_sqz = (widx % depth == depth - 1) && (widx < words - 1);
                check($sformatf("squeeze_w%0d", widx), 64'(squeeze_req_o), 64'(exp_sqz));
                widx++;
                last_x = cycle;
            end
            if (squeeze_req_o) squeezes++;
            stalled = valid_o && !ready_i;
            pd = data_o;
            pl = last_o;
            hs = state_ready_o && state_valid_i;
            if (done_o) begin
                check("done_latency", 64'(cycle), 64'(last_x + 1));
                break;
            end
            budget++;
            if (budget > 3000) begin
                check("timeout", 64'(budget), 64'd0);
                break;
            end
            @(posedge clk); #1;
            if (hs) begin
                blk++;
                state_i = build_block(pat, blk);
            end
            ready_i = bp ? !ready_i : 1'b1;
        end

        check("word_count", 64'(widx), 64'(words));
        check("squeeze_count", 64'(squeezes), 64'(exp_sq));
        check("sb_empty", 64'(sb.size()), 64'd0);
        if (words == 0) begin
            check("zero_no_sready", 64'(seen_rdy), 64'd0);
            check("zero_no_valid", 64'(seen_val), 64'd0);
        end
        sb.delete();
        @(posedge clk); #1;
        state_valid_i = 1'b0;
        ready_i = 1'b0;
        check("done_pulse_end", 64'(done_o), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        run_msg(M128, 256, 0, 0, 0);
        run_msg(M256, 1152, 1, 0, 0);
        run_msg(M128, 2688, 1, 0, 0);
        run_msg(M128, 200, 2, 0, 0);
        run_msg(M128, 256, 1, 1, 0);
        run_msg(M128, 0, 0, 0, 0);
        run_msg(2'b10, 1408, 1, 0, 0);
        run_msg(M128, 256, 0, 0, 2);
        run_msg(M256, 328, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
